jesd_tx_link_ctrl: RTL and testbench

JESD_TX_LINK_CTRL -- requirements
Module: jesd_tx_link_ctrl

---
 rtl/jesd_tx_pkg.sv | 40 ++++
 rtl/jesd_sync_monitor.sv | 46 ++++
 rtl/jesd_tx_link_ctrl.sv | 116 +++++++++++
 tb/tb_jesd_tx_link_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/jesd_tx_pkg.sv
// Shared encodings and helpers for the JESD204 transmit link controller.
// Holds link states, per-lane mux selects, the ILA minimum and the Kmin lookup.
package jesd_tx_pkg;

  typedef enum logic [1:0] {
    ST_SYNC      = 2'd0,
    ST_INIT_LANE = 2'd1,
    ST_DATA_ENC  = 2'd2
  } link_state_e;

  localparam logic [1:0] MUX_DATA = 2'd0;
  localparam logic [1:0] MUX_K    = 2'd1;
  localparam logic [1:0] MUX_ILA  = 2'd2;
  localparam logic [1:0] MUX_IDLE = 2'd3;

  localparam logic [7:0] ILA_MIN_MF = 8'd4;

  // Minimum number of K frames before ILA may start, indexed by octets-per-frame minus 1.
  function automatic logic [3:0] kmin_lookup(input logic [7:0] f_m1);
    logic [3:0] k;
    if (f_m1 == 8'd0)      k = 4'd10;
    else if (f_m1 == 8'd1) k = 4'd6;
    else if (f_m1 <= 8'd3) k = 4'd4;
    else if (f_m1 <= 8'd7) k = 4'd3;
    else                   k = 4'd2;
    return k;
  endfunction

  function automatic logic [1:0] state_mux(input link_state_e s);
    logic [1:0] m;
    case (s)
      ST_SYNC:      m = MUX_K;
      ST_INIT_LANE: m = MUX_ILA;
      ST_DATA_ENC:  m = MUX_DATA;
      default:      m = MUX_K;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/jesd_sync_monitor.sv
// Watches SYNC~ while the link is in data mode: counts consecutive low frames
// and flags error-report pulses (short lows that end before the resync limit).
module jesd_sync_monitor
  import jesd_tx_pkg::*;
#(
  parameter int RESYNC_FRAMES = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic frame_clk,
  input  logic sync_n,
  output logic resync_req,
  output logic err_report
);

  localparam logic [3:0] RESYNC_LIM  = 4'(RESYNC_FRAMES);
  localparam logic [3:0] RESYNC_LAST = 4'(RESYNC_FRAMES - 1);

  logic [3:0] low_cnt;
  logic       sync_n_q;
  logic       frame_low;
  logic       rise;

  assign frame_low  = active && frame_clk && !sync_n;
  assign rise       = sync_n && !sync_n_q;
  // Resync fires combinationally on the frame strobe that completes the low run.
  assign resync_req = frame_low && (low_cnt == RESYNC_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_n_q   <= 1'b1;
      low_cnt    <= 4'd0;
      err_report <= 1'b0;
    end else begin
      sync_n_q   <= sync_n;
      err_report <= active && rise && (low_cnt < RESYNC_LIM);
      if (!active || resync_req || rise) begin
        low_cnt <= 4'd0;
      end else if (frame_low) begin
        low_cnt <= low_cnt + 4'd1;
      end
    end
  end

endmodule

// File: rtl/jesd_tx_link_ctrl.sv
// JESD204 transmit link controller: CGS (K chars), ILA sequence, then user data,
// with SYNC~-driven re-initialisation and per-lane output select.
module jesd_tx_link_ctrl
  import jesd_tx_pkg::*;
#(
  parameter int L             = 4,
  parameter int SUBCLASS      = 1,
  parameter int RESYNC_FRAMES = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_frame_clk,
  input  logic           i_lmfc_clk,
  input  logic           i_sync_n,
  input  logic [L-1:0]   i_lane_en,
  input  logic [7:0]     i_F,
  input  logic [7:0]     i_ila_multiframe_length,
  output logic [2*L-1:0] o_link_mux,
  output logic [1:0]     o_state,
  output logic [7:0]     o_ila_mf_idx,
  output logic           o_ila_cfg_mf,
  output logic           o_err_report,
  output logic [7:0]     o_resync_cnt
);

  link_state_e state_q;
  link_state_e state_d;
  logic [7:0]  idx_d;
  logic [7:0]  f_q;
  logic [7:0]  ila_len_q;
  logic [7:0]  ila_last;
  logic [3:0]  kcnt_q;
  logic [3:0]  kmin;
  logic        start_strobe;
  logic        resync_req;

  assign o_state      = state_q;
  assign kmin         = kmin_lookup(f_q);
  assign start_strobe = (SUBCLASS == 1) ? i_lmfc_clk : i_frame_clk;
  // Index of the final ILA multiframe: max(len, ILA_MIN_MF-1), avoids the 8-bit N overflow.
  assign ila_last     = (ila_len_q < (ILA_MIN_MF - 8'd1)) ? (ILA_MIN_MF - 8'd1) : ila_len_q;

  jesd_sync_monitor #(
    .RESYNC_FRAMES(RESYNC_FRAMES)
  ) u_sync_monitor (
    .clk        (clk),
    .rst        (rst),
    .active     (state_q == ST_DATA_ENC),
    .frame_clk  (i_frame_clk),
    .sync_n     (i_sync_n),
    .resync_req (resync_req),
    .err_report (o_err_report)
  );

  always_comb begin
    state_d = ST_SYNC;
    idx_d   = 8'd0;
    case (state_q)
      ST_SYNC: begin
        if (start_strobe && i_sync_n && (kcnt_q >= kmin)) state_d = ST_INIT_LANE;
        else                                              state_d = ST_SYNC;
      end
      ST_INIT_LANE: begin
        if (!i_sync_n) begin
          state_d = ST_SYNC;
        end else if (i_lmfc_clk) begin
          if (o_ila_mf_idx == ila_last) begin
            state_d = ST_DATA_ENC;
          end else begin
            state_d = ST_INIT_LANE;
            idx_d   = o_ila_mf_idx + 8'd1;
          end
        end else begin
          state_d = ST_INIT_LANE;
          idx_d   = o_ila_mf_idx;
        end
      end
      ST_DATA_ENC: state_d = resync_req ? ST_SYNC : ST_DATA_ENC;
      default:     state_d = ST_SYNC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_SYNC;
      o_link_mux   <= {L{MUX_K}};
      o_ila_mf_idx <= 8'd0;
      o_ila_cfg_mf <= 1'b0;
      o_resync_cnt <= 8'd0;
      kcnt_q       <= 4'd0;
      f_q          <= i_F;
      ila_len_q    <= i_ila_multiframe_length;
    end else begin
      state_q      <= state_d;
      o_ila_mf_idx <= idx_d;
      o_ila_cfg_mf <= (state_d == ST_INIT_LANE) && (idx_d == 8'd1);
      for (int n = 0; n < L; n++) begin
        o_link_mux[2*n +: 2] <= i_lane_en[n] ? state_mux(state_d) : MUX_IDLE;
      end
      if ((state_q == ST_DATA_ENC) && resync_req && (o_resync_cnt != 8'hFF)) begin
        o_resync_cnt <= o_resync_cnt + 8'd1;
      end
      // Link parameters are only sampled when (re)entering SYNC.
      if ((state_d == ST_SYNC) && (state_q != ST_SYNC)) begin
        f_q       <= i_F;
        ila_len_q <= i_ila_multiframe_length;
      end
      if ((state_q != ST_SYNC) || !i_sync_n || (state_d != ST_SYNC)) begin
        kcnt_q <= 4'd0;
      end else if (i_frame_clk && (kcnt_q != 4'hF)) begin
        kcnt_q <= kcnt_q + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_jesd_tx_link_ctrl.sv
// Directed bench for jesd_tx_link_ctrl: CGS timing, ILA length, error report,
// resync, lane enables, reset mid-ILA and resync counter saturation.
module tb_jesd_tx_link_ctrl;

  localparam int L = 4;
  localparam int P = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           frame_clk;
  logic           lmfc_clk;
  logic           sync_n;
  logic [L-1:0]   lane_en;
  logic [7:0]     f_m1;
  logic [7:0]     ila_len;
  logic [2*L-1:0] link_mux;
  logic [1:0]     state;
  logic [7:0]     ila_mf_idx;
  logic           ila_cfg_mf;
  logic           err_report;
  logic [7:0]     resync_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  jesd_tx_link_ctrl #(.L(L), .SUBCLASS(1), .RESYNC_FRAMES(5)) dut (
    .clk                     (clk),
    .rst                     (rst),
    .i_frame_clk             (frame_clk),
    .i_lmfc_clk              (lmfc_clk),
    .i_sync_n                (sync_n),
    .i_lane_en               (lane_en),
    .i_F                     (f_m1),
    .i_ila_multiframe_length (ila_len),
    .o_link_mux              (link_mux),
    .o_state                 (state),
    .o_ila_mf_idx            (ila_mf_idx),
    .o_ila_cfg_mf            (ila_cfg_mf),
    .o_err_report            (err_report),
    .o_resync_cnt            (resync_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cycle(input logic fr, input logic lm);
    frame_clk = fr;
    lmfc_clk  = lm;
    @(posedge clk);
    #1;
    frame_clk = 1'b0;
    lmfc_clk  = 1'b0;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      cycle(1'b1, 1'b0);
      cycle(1'b0, 1'b0);
    end
  endtask

  task automatic run_mfs(input int n, output int aa_cnt, output int cfg_cnt);
    aa_cnt  = (link_mux == 8'hAA) ? 1 : 0;
    cfg_cnt = ila_cfg_mf ? 1 : 0;
    for (int m = 0; m < n; m++) begin
      for (int c = 0; c < P; c++) begin
        cycle(1'b0, c == P - 1);
        if (link_mux == 8'hAA) aa_cnt++;
        if (ila_cfg_mf) cfg_cnt++;
      end
    end
  endtask

  int aa_cnt;
  int cfg_cnt;
  int err_cnt;
  int de_hits;

  initial begin
    rst       = 1'b1;
    frame_clk = 1'b0;
    lmfc_clk  = 1'b0;
    sync_n    = 1'b0;
    lane_en   = 4'hF;
    f_m1      = 8'd0;
    ila_len   = 8'd3;
    repeat (3) cycle(1'b0, 1'b0);
    check_eq("rst_state", state, 2'd0);
    check_eq("rst_mux", link_mux, 8'h55);
    check_eq("rst_idx", ila_mf_idx, 8'd0);
    check_eq("rst_cfg", ila_cfg_mf, 1'b0);
    check_eq("rst_err", err_report, 1'b0);
    check_eq("rst_resync", resync_cnt, 8'd0);

    // F=1 -> Kmin 10: LMFC after 9 frames must not start ILA, after 10 it must.
    rst    = 1'b0;
    sync_n = 1'b1;
    frames(9);
    cycle(1'b0, 1'b1);
    check_eq("k9_still_sync", state, 2'd0);
    frames(1);
    cycle(1'b0, 1'b1);
    check_eq("k10_init", state, 2'd1);
    check_eq("init_mux", link_mux, 8'hAA);
    check_eq("init_idx0", ila_mf_idx, 8'd0);

    // ila_len=3 -> four multiframes of ILA, cfg only in multiframe 1.
    run_mfs(4, aa_cnt, cfg_cnt);
    check_eq("ila3_aa", aa_cnt, 32);
    check_eq("ila3_cfg", cfg_cnt, 8);
    check_eq("ila3_data", state, 2'd2);
    check_eq("data_mux", link_mux, 8'h00);
    check_eq("data_idx0", ila_mf_idx, 8'd0);

    // Short SYNC~ low: one error report, no resync.
    sync_n = 1'b0;
    frames(2);
    sync_n  = 1'b1;
    err_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b0);
      if (err_report) err_cnt++;
    end
    check_eq("err_pulses", err_cnt, 1);
    check_eq("err_state", state, 2'd2);
    check_eq("err_resync", resync_cnt, 8'd0);

    // Five low frames: resync on the fifth strobe; new F/ila latched on entry.
    f_m1    = 8'd1;
    ila_len = 8'd0;
    sync_n  = 1'b0;
    frames(4);
    check_eq("low4_state", state, 2'd2);
    cycle(1'b1, 1'b0);
    check_eq("low5_state", state, 2'd0);
    check_eq("low5_mux", link_mux, 8'h55);
    check_eq("low5_resync", resync_cnt, 8'd1);

    // F=2 -> Kmin 6; changing i_F now must not alter it.
    f_m1   = 8'd0;
    sync_n = 1'b1;
    frames(5);
    cycle(1'b0, 1'b1);
    check_eq("k5_still_sync", state, 2'd0);
    frames(1);
    cycle(1'b0, 1'b1);
    check_eq("k6_init", state, 2'd1);
    f_m1 = 8'd1;

    // ila_len=0 still gives four multiframes.
    run_mfs(4, aa_cnt, cfg_cnt);
    check_eq("ila0_aa", aa_cnt, 32);
    check_eq("ila0_cfg", cfg_cnt, 8);
    check_eq("ila0_data", state, 2'd2);

    // Disabled lanes show idle regardless of state.
    lane_en = 4'b0101;
    cycle(1'b0, 1'b0);
    check_eq("lane_mux", link_mux, 8'b11_00_11_00);
    check_eq("lane_state", state, 2'd2);
    lane_en = 4'hF;
    cycle(1'b0, 1'b0);
    check_eq("lane_restore", link_mux, 8'h00);

    // SYNC~ low during ILA drops back to SYNC on the next edge, no count.
    sync_n = 1'b0;
    frames(5);
    check_eq("resync2", resync_cnt, 8'd2);
    sync_n = 1'b1;
    frames(6);
    cycle(1'b0, 1'b1);
    check_eq("reinit_state", state, 2'd1);
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    sync_n = 1'b0;
    cycle(1'b0, 1'b0);
    check_eq("ila_abort_state", state, 2'd0);
    check_eq("ila_abort_mux", link_mux, 8'h55);
    check_eq("ila_abort_resync", resync_cnt, 8'd2);

    // Reset mid-ILA.
    sync_n = 1'b1;
    frames(6);
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b1);
    check_eq("mid_ila_idx1", ila_mf_idx, 8'd1);
    check_eq("mid_ila_cfg", ila_cfg_mf, 1'b1);
    f_m1    = 8'd8;
    ila_len = 8'd0;
    rst     = 1'b1;
    cycle(1'b0, 1'b0);
    check_eq("mid_rst_state", state, 2'd0);
    check_eq("mid_rst_mux", link_mux, 8'h55);
    check_eq("mid_rst_idx", ila_mf_idx, 8'd0);
    check_eq("mid_rst_cfg", ila_cfg_mf, 1'b0);
    check_eq("mid_rst_resync", resync_cnt, 8'd0);
    rst = 1'b0;

    // 300 resyncs with F=9 (Kmin 2) and back-to-back strobes.
    de_hits = 0;
    for (int r = 0; r < 300; r++) begin
      sync_n = 1'b1;
      cycle(1'b1, 1'b0);
      cycle(1'b1, 1'b0);
      cycle(1'b0, 1'b1);
      repeat (4) cycle(1'b0, 1'b1);
      if (state == 2'd2) de_hits++;
      sync_n = 1'b0;
      repeat (5) cycle(1'b1, 1'b0);
      if (r == 254) check_eq("resync_255", resync_cnt, 8'd255);
    end
    check_eq("loop_data_hits", de_hits, 300);
    check_eq("resync_sat", resync_cnt, 8'd255);
    check_eq("loop_end_state", state, 2'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
